// File: rtl/stream_mux_pkg.sv
// Shared defaults and helpers for the stream_mux_n slice.
// Holds the default channel/width values and the round-robin pointer reset value.
package stream_mux_pkg;

    localparam int unsigned DEF_N_CH  = 4;
    localparam int unsigned DEF_WIDTH = 8;

    // Pointer starts at the last channel so the first search begins at channel 0.
    function automatic int unsigned rr_ptr_rst(input int unsigned n_ch);
        return n_ch - 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for stream_mux_n: searches ptr+1, ptr+2, ... with wrap.
// Owns the pointer, which moves to the granted channel only when adv is high.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int unsigned  N_CH  = DEF_N_CH,
    localparam int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    input  logic             adv,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_vld
);

    logic [SEL_W-1:0] ptr;

    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            idx = int'(unsigned'(ptr)) + i;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (!grant_vld && idx == k && req[k]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(k);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= SEL_W'(rr_ptr_rst(N_CH));
        end else if (adv && grant_vld) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Define STREAM_MUX_RR_EN to replace sel with an internal round-robin arbiter.
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter int unsigned  N_CH  = DEF_N_CH,
    parameter int unsigned  WIDTH = DEF_WIDTH,
    localparam int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_ch
);

    logic             load;
    logic             xfer;
    logic             ch_vld;
    logic [SEL_W-1:0] ch;
    logic [WIDTH-1:0] ch_data;

    assign load = !out_valid || out_ready;

`ifdef STREAM_MUX_RR_EN
    logic unused_sel;
    assign unused_sel = ^sel;

    rr_arbiter #(
        .N_CH(N_CH)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .adv       (xfer),
        .grant_idx (ch),
        .grant_vld (ch_vld)
    );
`else
    assign ch     = sel;
    assign ch_vld = 32'(sel) < N_CH;
`endif

    always_comb begin
        in_ready = '0;
        ch_data  = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (ch_vld && ch == SEL_W'(k)) begin
                in_ready[k] = load;
                ch_data     = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = |(in_ready & in_valid);

    // Without a transfer, data and channel hold their last values even when valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= ch_data;
            out_ch    <= ch;
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_n.sv
// Self-checking bench for stream_mux_n: vector table plus scoreboard of transferred words.
// A 3-channel instance covers the out-of-range select.
module tb_stream_mux_n;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data = 32'hD3C2B1A0;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;

    logic [23:0] in_data3 = 24'hC2B1A0;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [1:0]  sel3;
    logic [7:0]  out_data3;
    logic        out_valid3;
    logic        out_ready3;
    logic [1:0]  out_ch3;

    always #5 clk = ~clk;

    stream_mux_n #(.N_CH(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
    );

    stream_mux_n #(.N_CH(3), .WIDTH(8)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .sel       (sel3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_ch    (out_ch3)
    );

    typedef struct {
        logic [1:0] sel;
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
        logic [7:0] od;
        logic [1:0] oc;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic [1:0] c;
    } sb_t;

    int   errors = 0;
    int   checks = 0;
    logic prev_ov = 1'b0;
    sb_t  sbq[$];
    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] s, input logic [3:0] v, input logic r,
                                input logic [3:0] rdy, input logic ov, input logic [7:0] od,
                                input logic [1:0] oc);
        vec_t t;
        t.sel = s; t.vld = v; t.ordy = r; t.rdy = rdy; t.ov = ov; t.od = od; t.oc = oc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive, check in_ready, score the consumed word, queue the accepted word.
    task automatic run_vec(input vec_t v, input string name);
        sb_t e;
        sel = v.sel; in_valid = v.vld; out_ready = v.ordy;
        #1;
        chk($sformatf("%s.in_ready", name), 32'(in_ready), 32'(v.rdy));
        if (prev_ov && v.ordy) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s.scoreboard: got word %0h but expected none", name, out_data);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("%s.sb_data", name), 32'(out_data), 32'(e.d));
                chk($sformatf("%s.sb_ch", name), 32'(out_ch), 32'(e.c));
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (v.rdy[k] && v.vld[k]) begin
                e.d = in_data[k*8 +: 8];
                e.c = 2'(k);
                sbq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        chk($sformatf("%s.out_valid", name), 32'(out_valid), 32'(v.ov));
        chk($sformatf("%s.out_data", name), 32'(out_data), 32'(v.od));
        chk($sformatf("%s.out_ch", name), 32'(out_ch), 32'(v.oc));
        prev_ov = v.ov;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = '0; sel = '0; out_ready = 1'b0;
        in_valid3 = '0; sel3 = '0; out_ready3 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset.out_valid", 32'(out_valid), 0);
        chk("reset.out_data", 32'(out_data), 0);
        chk("reset.out_ch", 32'(out_ch), 0);
        rst = 1'b0;

        // Capture a word, then reset mid-stall: outputs clear before the next edge.
        run_vec(mk(2'd2, 4'b0100, 1'b0, 4'b0100, 1'b1, 8'hC2, 2'd2), "rst_load");
        #2 rst = 1'b1;
        #1;
        chk("async_rst.out_valid", 32'(out_valid), 0);
        chk("async_rst.out_data", 32'(out_data), 0);
        chk("async_rst.out_ch", 32'(out_ch), 0);
        sbq.delete();
        prev_ov = 1'b0;
        in_valid = '0;
        out_ready = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst.out_valid", 32'(out_valid), 0);
        chk("post_rst.out_data", 32'(out_data), 0);

`ifdef STREAM_MUX_RR_EN
        // Requests on 0,1,3: grants rotate 0,1,3 with a 2-cycle stall in the middle.
        tbl.push_back(mk(2'd0, 4'b1011, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0));
        tbl.push_back(mk(2'd0, 4'b1011, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1));
        tbl.push_back(mk(2'd0, 4'b1011, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3));
        tbl.push_back(mk(2'd0, 4'b1011, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0));
        tbl.push_back(mk(2'd0, 4'b1011, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0));
        tbl.push_back(mk(2'd0, 4'b1011, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0));
        tbl.push_back(mk(2'd0, 4'b1011, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1));
        tbl.push_back(mk(2'd0, 4'b1011, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3));
        tbl.push_back(mk(2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hD3, 2'd3));
`else
        // Select sweep.
        tbl.push_back(mk(2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0));
        tbl.push_back(mk(2'd1, 4'hF, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1));
        tbl.push_back(mk(2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 8'hC2, 2'd2));
        tbl.push_back(mk(2'd3, 4'hF, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3));
        // Back-pressure: C2 held while sel moves to 1.
        tbl.push_back(mk(2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 8'hC2, 2'd2));
        tbl.push_back(mk(2'd1, 4'hF, 1'b0, 4'b0000, 1'b1, 8'hC2, 2'd2));
        tbl.push_back(mk(2'd1, 4'hF, 1'b0, 4'b0000, 1'b1, 8'hC2, 2'd2));
        tbl.push_back(mk(2'd1, 4'hF, 1'b0, 4'b0000, 1'b1, 8'hC2, 2'd2));
        tbl.push_back(mk(2'd1, 4'hF, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1));
        // Drain: valid falls, data and channel hold.
        tbl.push_back(mk(2'd1, 4'h0, 1'b1, 4'b0010, 1'b0, 8'hB1, 2'd1));
        tbl.push_back(mk(2'd0, 4'h0, 1'b1, 4'b0001, 1'b0, 8'hB1, 2'd1));
        tbl.push_back(mk(2'd2, 4'b0011, 1'b1, 4'b0100, 1'b0, 8'hB1, 2'd1));
        tbl.push_back(mk(2'd0, 4'b0011, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0));
        tbl.push_back(mk(2'd3, 4'hF, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0));
        tbl.push_back(mk(2'd3, 4'hF, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3));
        tbl.push_back(mk(2'd0, 4'h0, 1'b1, 4'b0001, 1'b0, 8'hD3, 2'd3));
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end
        chk("sb_left", 32'(sbq.size()), 0);

`ifndef STREAM_MUX_RR_EN
        // Three channels: sel=3 selects nothing.
        sel3 = 2'd0; in_valid3 = 3'b111; out_ready3 = 1'b1;
        #1;
        chk("n3_sel0.in_ready", 32'(in_ready3), 32'b001);
        @(posedge clk);
        #1;
        chk("n3_sel0.out_valid", 32'(out_valid3), 1);
        chk("n3_sel0.out_data", 32'(out_data3), 32'hA0);
        chk("n3_sel0.out_ch", 32'(out_ch3), 0);
        sel3 = 2'd3;
        #1;
        chk("n3_sel3.in_ready", 32'(in_ready3), 0);
        @(posedge clk);
        #1;
        chk("n3_sel3.out_valid", 32'(out_valid3), 0);
        chk("n3_sel3.out_data", 32'(out_data3), 32'hA0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
